// File: rtl/output_serializer_pkg.sv
// output_serializer_pkg: shared state enum, field codes, command bit positions and default error byte
// The CSUM state exists only when OUTPUT_SERIALIZER_CHECKSUM_EN is defined.
package output_serializer_pkg;
`ifdef OUTPUT_SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, ERR} state_t;
`endif
  localparam logic [1:0] FIELD_HIGH = 2'd0;
  localparam logic [1:0] FIELD_LOW = 2'd1;
  localparam logic [1:0] FIELD_PERIOD = 2'd2;
  localparam logic [1:0] FIELD_ALL = 2'd3;
  localparam int CMD_FIELD_LSB = 0;
  localparam int CMD_CH_LSB = 2;
  localparam int CMD_ORDER_BIT = 6;
  localparam int CMD_RSVD_BIT = 7;
  localparam logic [7:0] DEF_ERR_CODE = 8'hEE;
endpackage

// File: rtl/output_serializer_if.sv
// output_serializer_if: command receive strobe and byte transmit valid/ready handshake
// Ports: rx_data/rx_valid (command in), tx_data/tx_valid (byte out), tx_ready (sink accept).
// master drives commands and ready; slave is the serializer.
interface output_serializer_if #(parameter int DATA_WIDTH = 8);
  logic [7:0] rx_data;
  logic rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
  modport slave (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/output_serializer_snapshot.sv
// output_serializer_snapshot: captures the selected channel words on load and presents byte idx
// Ports: clk, rst (async high), load, field, ch, msb_first, time_high/time_low/period (flat buses),
// idx (frame byte index), byte_out (byte idx in the captured byte order).
// Words are stored high at the bottom, then low, then period, so a full frame walks upward.
module output_serializer_snapshot
  import output_serializer_pkg::*;
#(
  parameter int COUNTER_BITS = 32,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int IW = 4
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic [1:0] field,
  input logic [3:0] ch,
  input logic msb_first,
  input logic [NUM_CHANNELS*COUNTER_BITS-1:0] time_high,
  input logic [NUM_CHANNELS*COUNTER_BITS-1:0] time_low,
  input logic [NUM_CHANNELS*COUNTER_BITS-1:0] period,
  input logic [IW-1:0] idx,
  output logic [DATA_WIDTH-1:0] byte_out
);
  localparam int BYTES = COUNTER_BITS / DATA_WIDTH;
  logic [3*COUNTER_BITS-1:0] snap, snap_next;
  logic [COUNTER_BITS-1:0] h, l, p;
  logic msb;
  logic [IW-1:0] w, b, bs;
  int off;
  always_comb begin
    h = '0;
    l = '0;
    p = '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (int'(ch) == c) begin
        h = time_high[c*COUNTER_BITS +: COUNTER_BITS];
        l = time_low[c*COUNTER_BITS +: COUNTER_BITS];
        p = period[c*COUNTER_BITS +: COUNTER_BITS];
      end
  end
  assign snap_next = field == FIELD_ALL ? {p, l, h} :
                     {{2*COUNTER_BITS{1'b0}}, field == FIELD_HIGH ? h : field == FIELD_LOW ? l : p};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snap <= '0;
      msb <= 1'b0;
    end else if (load) begin
      snap <= snap_next;
      msb <= msb_first;
    end
  assign w = idx / IW'(BYTES);
  assign b = idx - w * IW'(BYTES);
  assign bs = msb ? IW'(BYTES - 1) - b : b;
  assign off = int'(w) * COUNTER_BITS + int'(bs) * DATA_WIDTH;
  assign byte_out = DATA_WIDTH'(snap >> off);
endmodule

// File: rtl/output_serializer.sv
// output_serializer: decodes a command byte, snapshots channel measurements and streams them as bytes
// Ports: clk, rst (async high), bus (slave: rx_data/rx_valid in, tx_data/tx_valid out, tx_ready in),
// time_high/time_low/period (flat per-channel buses), busy, cmd_drop and cmd_error (one-cycle pulses).
// Define OUTPUT_SERIALIZER_CHECKSUM_EN to append an XOR checksum byte to every frame.
module output_serializer
  import output_serializer_pkg::*;
#(
  parameter int COUNTER_BITS = 32,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CHANNELS = 4,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE = DATA_WIDTH'(DEF_ERR_CODE)
) (
  input logic clk,
  input logic rst,
  output_serializer_if.slave bus,
  input logic [NUM_CHANNELS*COUNTER_BITS-1:0] time_high,
  input logic [NUM_CHANNELS*COUNTER_BITS-1:0] time_low,
  input logic [NUM_CHANNELS*COUNTER_BITS-1:0] period,
  output logic busy,
  output logic cmd_drop,
  output logic cmd_error
);
  localparam int BYTES = COUNTER_BITS / DATA_WIDTH;
  localparam int IW = $clog2(3 * BYTES);
  state_t state;
  logic [IW-1:0] idx, last;
  logic [DATA_WIDTH-1:0] snap_byte;
  logic [1:0] field;
  logic [3:0] ch;
  logic invalid, load, hs;
`ifdef OUTPUT_SERIALIZER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif
  assign field = bus.rx_data[CMD_FIELD_LSB +: 2];
  assign ch = bus.rx_data[CMD_CH_LSB +: 4];
  assign invalid = bus.rx_data[CMD_RSVD_BIT] || int'(ch) >= NUM_CHANNELS;
  assign load = state == IDLE && bus.rx_valid && !invalid;
  assign hs = bus.tx_valid && bus.tx_ready;
  assign busy = state != IDLE;
  assign bus.tx_valid = state != IDLE;
  assign bus.tx_data = state == SEND ? snap_byte : state == ERR ? ERR_CODE :
`ifdef OUTPUT_SERIALIZER_CHECKSUM_EN
                       state == CSUM ? csum :
`endif
                       '0;
  output_serializer_snapshot #(
    .COUNTER_BITS(COUNTER_BITS),
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_CHANNELS(NUM_CHANNELS),
    .IW(IW)
  ) u_snapshot (
    .clk(clk),
    .rst(rst),
    .load(load),
    .field(field),
    .ch(ch),
    .msb_first(bus.rx_data[CMD_ORDER_BIT]),
    .time_high(time_high),
    .time_low(time_low),
    .period(period),
    .idx(idx),
    .byte_out(snap_byte)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      last <= '0;
      cmd_drop <= 1'b0;
      cmd_error <= 1'b0;
`ifdef OUTPUT_SERIALIZER_CHECKSUM_EN
      csum <= '0;
`endif
    end else begin
      cmd_drop <= bus.rx_valid && state != IDLE;
      cmd_error <= bus.rx_valid && state == IDLE && invalid;
      case (state)
        IDLE: if (bus.rx_valid) begin
          state <= invalid ? ERR : SEND;
          idx <= '0;
          last <= field == FIELD_ALL ? IW'(3 * BYTES - 1) : IW'(BYTES - 1);
`ifdef OUTPUT_SERIALIZER_CHECKSUM_EN
          csum <= '0;
`endif
        end
        SEND: if (hs) begin
`ifdef OUTPUT_SERIALIZER_CHECKSUM_EN
          csum <= csum ^ snap_byte;
          if (idx == last) state <= CSUM;
`else
          if (idx == last) state <= IDLE;
`endif
          else idx <= idx + 1'b1;
        end
`ifdef OUTPUT_SERIALIZER_CHECKSUM_EN
        ERR: if (hs) begin
          state <= CSUM;
          csum <= ERR_CODE;
        end
        CSUM: if (hs) state <= IDLE;
`else
        ERR: if (hs) state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_output_serializer.sv
// tb_output_serializer: scoreboard bench for output_serializer with per-scenario tasks
module tb_output_serializer;
  localparam int CB = 32;
  localparam int NC = 4;
`ifdef OUTPUT_SERIALIZER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC*CB-1:0] th, tl, pd;
  logic busy, cmd_drop, cmd_error;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  output_serializer_if #(.DATA_WIDTH(8)) bus();
  output_serializer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .time_high(th),
    .time_low(tl),
    .period(pd),
    .busy(busy),
    .cmd_drop(cmd_drop),
    .cmd_error(cmd_error)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && bus.tx_valid && bus.tx_ready) begin
      logic [7:0] e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL byte_unexpected got %02h want none", bus.tx_data);
      end else begin
        e = sb.pop_front();
        if (bus.tx_data !== e) begin
          errors++;
          $display("FAIL byte got %02h want %02h", bus.tx_data, e);
        end
      end
    end
  task automatic set_inputs();
    th = {32'h3333_3333, 32'h8765_4321, 32'h1234_5678, 32'h1111_1111};
    tl = {32'h4444_4444, 32'hCAFE_BABE, 32'h8765_4321, 32'h5555_5555};
    pd = {32'h6666_6666, 32'h7777_7777, 32'hABCD_EF01, 32'h8888_8888};
  endtask
  task automatic exp_frame(input logic [95:0] v, input int n);
    logic [7:0] x, b;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = v[8*(n-1-i) +: 8];
      sb.push_back(b);
      x ^= b;
    end
    if (CS == 1) sb.push_back(x);
  endtask
  task automatic send_cmd(input logic [7:0] c);
    @(posedge clk);
    #1 bus.rx_data = c;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask
  task automatic wait_frame(input string name, input int len, input int ce_exp);
    int n, ce, t;
    n = 0;
    ce = 0;
    t = 0;
    while (t < 200) begin
      @(negedge clk);
      t++;
      if (cmd_error) ce++;
      if (!bus.tx_valid) break;
      n++;
    end
    checks += 4;
    if (n !== len) begin errors++; $display("FAIL %s_valid_cycles got %0d want %0d", name, n, len); end
    if (ce !== ce_exp) begin errors++; $display("FAIL %s_cmd_error got %0d want %0d", name, ce, ce_exp); end
    if (sb.size() !== 0) begin errors++; $display("FAIL %s_leftover got %0d want 0", name, sb.size()); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %b want 0", name, busy); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", bus.tx_valid); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %02h want 00", bus.tx_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (cmd_drop !== 1'b0) begin errors++; $display("FAIL rst_cmd_drop got %b want 0", cmd_drop); end
    if (cmd_error !== 1'b0) begin errors++; $display("FAIL rst_cmd_error got %b want 0", cmd_error); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_lsb();
    exp_frame(96'h78563412, 4);
    send_cmd(8'h04);
    wait_frame("lsb", 4 + CS, 0);
  endtask
  task automatic test_msb();
    exp_frame(96'h12345678, 4);
    send_cmd(8'h44);
    wait_frame("msb", 4 + CS, 0);
    exp_frame(96'hCAFEBABE, 4);
    send_cmd(8'h49);
    wait_frame("msb_ch2_low", 4 + CS, 0);
  endtask
  task automatic test_all_snapshot();
    exp_frame(96'h785634122143658701EFCDAB, 12);
    send_cmd(8'h07);
    th[CB +: CB] = 32'hFFFF_0000;
    tl[CB +: CB] = 32'h0000_FFFF;
    pd[CB +: CB] = 32'h5A5A_5A5A;
    wait_frame("all", 12 + CS, 0);
    set_inputs();
  endtask
  task automatic test_stall_drop();
    exp_frame(96'h78563412, 4);
    send_cmd(8'h04);
    @(posedge clk);
    #1 bus.tx_ready = 1'b0;
    bus.rx_data = 8'h08;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.tx_data !== 8'h56 || bus.tx_valid !== 1'b1) begin errors++; $display("FAIL stall_hold1 got %02h/%b want 56/1", bus.tx_data, bus.tx_valid); end
    if (cmd_drop !== 1'b0) begin errors++; $display("FAIL drop_early got %b want 0", cmd_drop); end
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.tx_data !== 8'h56 || bus.tx_valid !== 1'b1) begin errors++; $display("FAIL stall_hold2 got %02h/%b want 56/1", bus.tx_data, bus.tx_valid); end
    if (cmd_drop !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b want 1", cmd_drop); end
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (bus.tx_data !== 8'h56 || bus.tx_valid !== 1'b1) begin errors++; $display("FAIL stall_hold3 got %02h/%b want 56/1", bus.tx_data, bus.tx_valid); end
    if (cmd_drop !== 1'b0) begin errors++; $display("FAIL drop_width got %b want 0", cmd_drop); end
    @(posedge clk);
    #1 bus.tx_ready = 1'b1;
    wait_frame("stall", 3 + CS, 0);
  endtask
  task automatic test_errors();
    exp_frame(96'hEE, 1);
    send_cmd(8'h10);
    wait_frame("err_channel", 1 + CS, 1);
    exp_frame(96'hEE, 1);
    send_cmd(8'h80);
    wait_frame("err_reserved", 1 + CS, 1);
  endtask
  task automatic test_reset_midframe();
    sb.push_back(8'h78);
    sb.push_back(8'h56);
    send_cmd(8'h04);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks += 4;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_tx_valid got %b want 0", bus.tx_valid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data got %02h want 00", bus.tx_data); end
    if (sb.size() !== 0) begin errors++; $display("FAIL midrst_bytes_left got %0d want 0", sb.size()); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got %b/%b want 0/0", busy, bus.tx_valid); end
    exp_frame(96'h21436587, 4);
    send_cmd(8'h08);
    wait_frame("after_rst", 4 + CS, 0);
  endtask
  initial begin
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    set_inputs();
    test_reset();
    test_lsb();
    test_msb();
    test_all_snapshot();
    test_stall_drop();
    test_errors();
    test_reset_midframe();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/output_serializer.md
# output_serializer

Multi-channel successor to the single-channel output selector. It accepts a command byte from the UART receive path, selects one channel and one or all of its pulse-width measurements (time_high, time_low, period), and snapshots the selection atomically. It then streams the snapshot as DATA_WIDTH-bit bytes to the UART transmit path over a valid/ready handshake, in a selectable byte order. It sits between the per-channel pulse-width counters and the UART TX.

## Interface
- COUNTER_BITS, 32, width of each measurement; must be an integer multiple of DATA_WIDTH
- DATA_WIDTH, 8, output byte width
- NUM_CHANNELS, 4, measured channels, 1..16
- ERR_CODE, 8'hEE, byte sent in response to an invalid command
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  command byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- time_high  in  NUM_CHANNELS*COUNTER_BITS  flat bus, channel c at bits [c*COUNTER_BITS +: COUNTER_BITS]
- time_low  in  NUM_CHANNELS*COUNTER_BITS  same layout
- period  in  NUM_CHANNELS*COUNTER_BITS  same layout
- tx_data  out  DATA_WIDTH  current output byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready
- busy  out  1  frame in progress (state != IDLE)
- cmd_drop  out  1  one-cycle pulse, command arrived while busy and was discarded
- cmd_error  out  1  one-cycle pulse, invalid command accepted

## Operation
- Command decode: [1:0] field (0 high, 1 low, 2 period, 3 all), [5:2] channel, [6] order (0 LSB-first, 1 MSB-first), [7] reserved, must be 0.
- Invalid command: channel >= NUM_CHANNELS or bit 7 set. Response is a one-byte frame of ERR_CODE; cmd_error pulses on the accept cycle.
- BYTES = COUNTER_BITS/DATA_WIDTH. The frame length is BYTES, or 3*BYTES for field 3, sent in the order high, low, period. The configured byte order applies within each word.
- FSM states: IDLE, SEND, CSUM (only with the macro), ERR.
  - IDLE→SEND on rx_valid with a valid command. The selected words are copied into a snapshot register on the same edge.
  - IDLE→ERR on rx_valid with an invalid command.
  - SEND advances the byte index on each handshake. After the last byte it goes to CSUM if the macro is enabled, otherwise to IDLE.
  - ERR→IDLE on handshake. CSUM→IDLE on handshake.
- Live measurement inputs are ignored after the snapshot. A frame always carries a coherent set of values.
- rx_valid while busy: the command is discarded, cmd_drop pulses, and the current frame is unaffected.

## Timing
- Reset values: tx_valid 0, tx_data 0, busy 0, cmd_drop 0, cmd_error 0, state IDLE, byte index 0, snapshot 0.
- Latency: the command is accepted at edge N, and tx_valid is high with the first byte after edge N.
- tx_valid is high continuously from the first byte to the last byte of a frame. It drops on the edge that completes the final handshake.
- A new command can be accepted in the cycle after tx_valid falls.
- Handshake: one byte per cycle at most when tx_ready is held high. While tx_valid && !tx_ready, tx_data and tx_valid must hold stable.
- Reset asserted mid-frame: all outputs return to their reset values immediately, with no partial-frame resume. After release, the block is idle and waits for a new command.
- rx_valid together with the final handshake of a frame: the block is still busy on that cycle, so the command is dropped.

## Configuration
- OUTPUT_SERIALIZER_CHECKSUM_EN defined:
  - After the payload, one extra byte is sent in state CSUM. It is the XOR of all payload bytes.
  - An ERR frame is ERR_CODE followed by the checksum ERR_CODE.
- Not defined: no CSUM state, and frames are payload only.

## Structure
- Package output_serializer_pkg:
  - state enum
  - field codes (FIELD_HIGH, FIELD_LOW, FIELD_PERIOD, FIELD_ALL)
  - command bit positions
  - default ERR_CODE
- One sub-module, output_serializer_snapshot:
  - muxes the channel and fields into a 3*COUNTER_BITS register on load
  - presents byte k for the current index and order
- The top holds the FSM, handshake, pulses and checksum.

## Test plan
Defaults throughout. ch1: time_high=32'h12345678, time_low=32'h87654321, period=32'hABCDEF01. tx_ready=1 unless stated.
- Cmd 8'h04 → bytes 78 56 34 12 on 4 consecutive cycles, first one cycle after the command. With the macro, a 5th byte 08 follows.
- Cmd 8'h44 → 12 34 56 78.
- Cmd 8'h07 → 12 bytes: 78 56 34 12 21 43 65 87 01 EF CD AB. Change the ch1 inputs mid-frame → the output is unchanged.
- Cmd 8'h04, tx_ready low for 3 cycles after byte 2 → byte 56 is held stable, and no byte is lost or duplicated. A second cmd 8'h08 mid-frame → cmd_drop pulses once and the frame is intact.
- Cmd 8'h10 (channel 4) and cmd 8'h80 → each produces a single EE (EE EE with the macro) and a one-cycle cmd_error pulse.
- Cmd 8'h04, rst pulsed after byte 2 → tx_valid and busy go to 0 asynchronously. After release, cmd 8'h08 streams 21 43 65 87 correctly.
